// File: rtl/mac_seq_ctrl.sv
// Sequencer for an external combinational mac_8in: it accumulates len+1 operand-pair
// dot products into a wrapping psum and presents the result with a valid/ready handshake.
module mac_seq_ctrl #(
  parameter int bw      = 8,
  parameter int bw_psum = 32,
  parameter int pr      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [3:0]          len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [pr*bw-1:0]    in_a,
  input  logic [pr*bw-1:0]    in_b,
  output logic [pr*bw-1:0]    mac_a,
  output logic [pr*bw-1:0]    mac_b,
  input  logic [bw_psum-1:0]  mac_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [bw_psum-1:0]  out_psum,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [bw_psum-1:0]  acc_r;
  logic [3:0]          cnt_r;
  logic [3:0]          len_r;
  logic                hs_s;

  // Outputs are decoded from the state register only, so they never depend on
  // input timing except for the operand pass-through to the external MAC.
  assign in_ready  = (state_r == ACCUM);
  assign out_valid = (state_r == OUT);
  assign busy      = (state_r != IDLE);
  assign hs_s      = in_valid && (state_r == ACCUM);
  assign out_psum  = (state_r == OUT)   ? acc_r : {bw_psum{1'b0}};
  assign mac_a     = (state_r == ACCUM) ? in_a  : {(pr*bw){1'b0}};
  assign mac_b     = (state_r == ACCUM) ? in_b  : {(pr*bw){1'b0}};

  // Next-state decode; the last chunk is the handshake where the counter reaches len.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = ACCUM;
        else       state_s = IDLE;
      end
      ACCUM: begin
        if (hs_s && (cnt_r == len_r)) state_s = OUT;
        else                          state_s = ACCUM;
      end
      OUT: begin
        if (out_ready) state_s = IDLE;
        else           state_s = OUT;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, accumulator, chunk counter and job length; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      acc_r   <= {bw_psum{1'b0}};
      cnt_r   <= 4'd0;
      len_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (start) begin
            len_r <= len;
            acc_r <= {bw_psum{1'b0}};
            cnt_r <= 4'd0;
          end
        end
        ACCUM: begin
          if (hs_s) begin
            acc_r <= acc_r + mac_out;
            cnt_r <= cnt_r + 4'd1;
          end
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl: stimulus pushes expected psums into a queue and a
// monitor pops and compares them on every output handshake.
module tb_mac_seq_ctrl;

  localparam int BW = 8;
  localparam int BWP = 32;
  localparam int PR = 8;

  logic            clk;
  logic            reset;
  logic            start;
  logic [3:0]      len;
  logic            in_valid;
  logic            in_ready;
  logic [63:0]     in_a;
  logic [63:0]     in_b;
  logic [63:0]     mac_a;
  logic [63:0]     mac_b;
  logic [31:0]     mac_out;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_psum;
  logic            busy;

  logic            force_en;
  logic [31:0]     force_val;
  logic [31:0]     mac_model;

  int              n_vec;
  int              n_err;
  logic [31:0]     exp_q[$];
  logic [63:0]     vec;

  mac_seq_ctrl #(.bw(BW), .bw_psum(BWP), .pr(PR)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_out(mac_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference mac_8in: unsigned sum of byte-wise products, truncated to 32 bits.
  always_comb begin
    mac_model = 32'd0;
    for (int i = 0; i < PR; i++)
      mac_model = mac_model + (32'(mac_a[i*8 +: 8]) * 32'(mac_b[i*8 +: 8]));
  end
  assign mac_out = force_en ? force_val : mac_model;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: every accepted psum must match the oldest expectation.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_psum: got 0x%0h expected no output", out_psum);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (out_psum !== e) begin
          n_err++;
          $display("FAIL psum: got 0x%0h expected 0x%0h", out_psum, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] l);
    len = l;
    start = 1'b1;
    tick();
    start = 1'b0;
    len = 4'd0;
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b);
    bit ok;
    ok = 1'b0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready stayed 0 expected 1");
    end
    tick();
    in_valid = 1'b0;
    in_a = 64'd0;
    in_b = 64'd0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    vec = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    reset = 1'b1; start = 1'b0; len = 4'd0; in_valid = 1'b0;
    in_a = 64'd0; in_b = 64'd0; out_ready = 1'b1;
    force_en = 1'b0; force_val = 32'd0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_psum", 64'(out_psum), 64'd0);
    chk("rst_mac_a", mac_a, 64'd0);
    chk("rst_mac_b", mac_b, 64'd0);
    tick();

    // Single chunk; operands are also shown in IDLE, where they must be blocked
    in_a = vec; in_b = vec;
    @(negedge clk);
    chk("idle_mac_a", mac_a, 64'd0);
    tick();
    do_start(4'd0);
    in_a = vec; in_b = vec;
    @(negedge clk);
    chk("accum_in_ready", 64'(in_ready), 64'd1);
    chk("accum_mac_a", mac_a, vec);
    chk("accum_mac_b", mac_b, vec);
    tick();
    exp_q.push_back(32'd204);
    send(vec, vec);
    @(negedge clk);
    chk("single_latency", 64'(out_valid), 64'd1);
    tick();
    @(negedge clk);
    chk("single_idle", 64'(busy), 64'd0);
    tick();

    // Multi-chunk with bubbles, then backpressure in OUT
    out_ready = 1'b0;
    do_start(4'd2);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) exp_q.push_back(32'd612);
      send(vec, vec);
      if (k < 2) begin
        @(negedge clk);
        chk("multi_no_early_valid", 64'(out_valid), 64'd0);
        tick();
        tick();
      end
    end
    for (int k = 0; k < 5; k++) begin
      start = k[0];
      len = 4'd0;
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_psum", 64'(out_psum), 64'd612);
      chk("bp_busy", 64'(busy), 64'd1);
      tick();
    end
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("bp_return_idle", 64'(busy), 64'd0);
    chk("bp_start_ignored", 64'(in_ready), 64'd0);
    tick();

    // Accumulator wrap
    do_start(4'd1);
    force_en = 1'b1;
    exp_q.push_back(32'h0000_0010);
    force_val = 32'hFFFF_FFF0;
    send(vec, vec);
    force_val = 32'h0000_0020;
    send(vec, vec);
    force_en = 1'b0;
    tick();

    // Reset mid-job: the aborted job must not produce any output
    do_start(4'd3);
    send(vec, vec);
    send(vec, vec);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    tick();
    do_start(4'd0);
    exp_q.push_back(32'd204);
    send(vec, vec);
    tick();

    // start during ACCUM must not re-latch len
    do_start(4'd1);
    send(vec, vec);
    do_start(4'd0);
    @(negedge clk);
    chk("accum_start_ignored", 64'(out_valid), 64'd0);
    tick();
    exp_q.push_back(32'd408);
    send(vec, vec);
    repeat (3) tick();

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running expected finish");
    $fatal(1);
  end

endmodule
